// File: rtl/asu_serial_adder.sv
// Bit-serial adder/subtractor/collator for the accumulator loop.
// One pulse interval (p.i.) per clock, LSB first; p.i. 34 is the sign bit
// and p.i. 35 is the inter-word guard gap.
module asu_serial_adder #(
    parameter int unsigned WORD_PI = 36
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sync,
    input  logic       acc,
    input  logic       opnd,
    input  logic       c_add,
    input  logic       c_sub,
    input  logic       c_col,
    input  logic       opnd2,
    input  logic       long_wd,
    input  logic       ovf_clr,
    output logic       adder_sum,
    output logic [5:0] pi,
    output logic       ovf
);

    typedef enum logic [1:0] {
        ORD_NONE,
        ORD_ADD,
        ORD_SUB,
        ORD_COL
    } order_t;

    localparam logic [5:0] PI_LAST  = 6'(WORD_PI - 1);
    localparam logic [5:0] PI_SIGN  = 6'(WORD_PI - 2);
    localparam logic [5:0] PI_SHORT = 6'd18;

    order_t     order_q;
    order_t     order_now;
    logic       long_q;
    logic       long_now;
    logic       cy_q;
    logic [5:0] eff_pi;
    logic [5:0] first_pi;
    logic [5:0] pi_next;
    logic       in_window;
    logic       x;
    logic       cy_in;
    logic       sum_bit;
    logic       cy_out;
    logic       ovf_set;

    // Per-p.i. datapath: order selection, effective operand, carry and sum.
    // sync makes the current clock p.i. 0 whatever the counter holds, so an
    // early sync simply re-samples the order and drops the partial word.
    always_comb begin
        eff_pi    = sync ? '0 : pi;
        order_now = order_q;
        long_now  = long_q;
        if (eff_pi == '0) begin
            long_now = long_wd;
            if (!sync)       order_now = ORD_NONE;
            else if (c_sub)  order_now = ORD_SUB;
            else if (c_add)  order_now = ORD_ADD;
            else if (c_col)  order_now = ORD_COL;
            else             order_now = ORD_NONE;
        end

        first_pi  = long_now ? '0 : PI_SHORT;
        in_window = (eff_pi >= first_pi) && (eff_pi <= PI_SIGN);

        x = 1'b0;
        if (in_window) begin
            case (order_now)
                ORD_ADD: x = opnd;
                ORD_SUB: x = ~opnd;
                ORD_COL: x = opnd & opnd2;
                default: x = 1'b0;
            endcase
        end

        if (order_now != ORD_NONE && eff_pi == first_pi)
            cy_in = (order_now == ORD_SUB);
        else if (eff_pi == '0)
            cy_in = 1'b0;
        else
            cy_in = cy_q;

        sum_bit = acc ^ x ^ cy_in;
        cy_out  = (acc & x) | (acc & cy_in) | (x & cy_in);
        ovf_set = (order_now != ORD_NONE) && (eff_pi == PI_SIGN) && (cy_in != cy_out);
        pi_next = (eff_pi == PI_LAST) ? '0 : eff_pi + 6'd1;
    end

    // State: p.i. counter, held order, carry FF, registered sum, sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pi        <= '0;
            order_q   <= ORD_NONE;
            long_q    <= 1'b0;
            cy_q      <= 1'b0;
            adder_sum <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            pi        <= pi_next;
            order_q   <= order_now;
            long_q    <= long_now;
            cy_q      <= (eff_pi == PI_LAST) ? 1'b0 : cy_out;
            adder_sum <= (eff_pi == PI_LAST) ? 1'b0 : sum_bit;
            if (ovf_set)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

endmodule

// File: doc/asu_serial_adder.md
ASU_SERIAL_ADDER -- requirements
Module: asu_serial_adder

Interface
REQ-001 SHALL have parameter WORD_PI, default 36, giving pulse intervals (p.i.) per minor cycle; only 36 is supported.
REQ-002 SHALL have ports: clk  input  1  single system clock, one p.i. per rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sync  input  1  high for one clk at p.i. 0 of every minor cycle.
REQ-005 SHALL have port acc  input  1  accumulator operand bit, LSB first (gated accumulator output).
REQ-006 SHALL have port opnd  input  1  store/multiplier operand bit, LSB first.
REQ-007 SHALL have port c_add  input  1  add order (A): sum = acc + opnd.
REQ-008 SHALL have port c_sub  input  1  subtract order (S): sum = acc - opnd.
REQ-009 SHALL have port c_col  input  1  collate order (C): sum = acc + (opnd & mask); mask bit arrives on opnd2.
REQ-010 SHALL have port opnd2  input  1  collate mask bit (multiplier register bit), LSB first.
REQ-011 SHALL have port long_wd  input  1  1 = 35-bit long-word order, 0 = 17-bit short-word order.
REQ-012 SHALL have port ovf_clr  input  1  synchronous clear of sticky overflow.
REQ-013 SHALL have port adder_sum  output  1  registered serial sum to accumulator store II.
REQ-014 SHALL have port pi  output  6  current p.i. count 0..35.
REQ-015 SHALL have port ovf  output  1  sticky arithmetic overflow flag.

Function
REQ-016 SHALL keep a p.i. counter: sync forces next value 1 (current p.i. treated as 0); otherwise increments and wraps 35 -> 0.
REQ-017 SHALL define the active window as p.i. 0..34 for long_wd=1 and p.i. 18..34 for long_wd=0; p.i. 34 is the sign bit; p.i. 35 is the guard gap.
REQ-018 SHALL sample c_add, c_sub, c_col, long_wd at p.i. 0 only and hold them for the minor cycle; changes mid-cycle SHALL be ignored.
REQ-019 SHALL form the effective operand x: inside the window, opnd (A), ~opnd (S), opnd & opnd2 (C); outside the window 0; when no order is latched, 0.
REQ-020 SHALL preset the carry FF to 1 at the first window p.i. when S is latched, otherwise to 0, before that bit's addition.
REQ-021 SHALL compute per p.i. s = acc ^ x ^ cy, cy_next = majority(acc, x, cy), and register s into adder_sum (latency 1 clk).
REQ-022 SHALL force adder_sum to 0 for the bit computed at p.i. 35 and clear carry at p.i. 35.
REQ-023 SHALL pass acc unchanged (x=0, cy=0) when no order is latched, so the accumulator recirculates.
REQ-024 SHALL set ovf when, at p.i. 34 with an order latched, carry-into-sign differs from carry-out-of-sign; ovf SHALL stay set until ovf_clr or reset.
REQ-025 SHALL give set priority over ovf_clr when both occur in the same clk.
REQ-026 SHALL, if sync arrives early (counter not at 35), restart at p.i. 0, clear carry and discard the partial cycle's latched order.
REQ-027 SHALL treat simultaneous c_add/c_sub/c_col as priority S > A > C.

Reset
REQ-028 SHALL on reset_n low asynchronously clear: counter to 0, carry 0, adder_sum 0, ovf 0, latched order none.
REQ-029 SHALL after reset release resume counting from p.i. 0 and produce recirculation until the first sync-sampled order.
REQ-030 SHALL, on reset mid-cycle, abandon the current word; no partial sum SHALL be flagged as overflow.

Verification
REQ-031 Long A: acc=5, opnd=3, long_wd=1 -> adder_sum serial value 8 over p.i. 0..34, 0 at p.i. 35, ovf=0.
REQ-032 Long S: acc=3, opnd=5 -> adder_sum = 2^35-2 (two's complement -2), sign bit 1, ovf=0.
REQ-033 Short A: acc=0, opnd=1 at p.i. 18, long_wd=0 -> adder_sum bit set only at p.i. 18; opnd bits at p.i. 0..17 ignored.
REQ-034 Overflow: acc=2^34-1, opnd=1, long A -> sign bit 1, ovf=1 from p.i. 35; ovf_clr same clk as a new overflow -> ovf stays 1.
REQ-035 Collate: acc=0, opnd=0b1111, opnd2=0b1010 -> adder_sum=0b1010.
REQ-036 Reset at p.i. 20 during S, then sync with no order -> adder_sum equals acc delayed 1 clk, ovf=0, pi restarts at 0.
